// File: rtl/reg_write_port_if.sv
// Bundle of the ALU/MDU writeback requests and the register-file write side
// seen by reg_write_port.
interface reg_write_port_if #(
    parameter int REG_WIDTH     = 8,
    parameter int REG_DIR_WIDTH = 3
);
    logic                     alu_valid;
    logic [REG_DIR_WIDTH-1:0] alu_dir;
    logic [REG_WIDTH-1:0]     alu_data;
    logic                     mdu_valid;
    logic [REG_DIR_WIDTH-1:0] mdu_dir;
    logic [REG_WIDTH-1:0]     mdu_data;
    logic                     mdu_ready;
    logic [REG_DIR_WIDTH-1:0] writer;
    logic [REG_WIDTH-1:0]     writedata;
    logic                     RegWrite;
    logic [1:0]               pend_cnt;

    modport master (
        output alu_valid, alu_dir, alu_data,
        output mdu_valid, mdu_dir, mdu_data,
        input  mdu_ready, writer, writedata, RegWrite, pend_cnt
    );

    modport slave (
        input  alu_valid, alu_dir, alu_data,
        input  mdu_valid, mdu_dir, mdu_data,
        output mdu_ready, writer, writedata, RegWrite, pend_cnt
    );
endinterface

// File: rtl/reg_write_port.sv
// Register-file write port arbitrating a single-cycle ALU against a multi-cycle
// unit; MDU results wait in a 2-entry FIFO and are squashed by newer ALU writes.
module reg_write_port #(
    parameter int REG_WIDTH     = 8,
    parameter int REG_DIR_WIDTH = 3
) (
    input logic             clk,
    input logic             rst,
    reg_write_port_if.slave bus
);

    logic [REG_DIR_WIDTH-1:0] qdir  [2];
    logic [REG_WIDTH-1:0]     qdata [2];
    logic [1:0]               qvld;
    logic                     wptr;
    logic                     rptr;
    logic [1:0]               cnt;

    logic                     alu_eff;
    logic                     mdu_ready;
    logic                     push;
    logic                     pop;

    logic                     wr_en;
    logic [REG_DIR_WIDTH-1:0] wr_dir;
    logic [REG_WIDTH-1:0]     wr_data;

    // Readiness depends only on occupancy so it never combinationally loops
    // through the pop decision.
    assign mdu_ready = (cnt < 2'd2);
    assign alu_eff   = bus.alu_valid && (bus.alu_dir != '0);
    assign push      = bus.mdu_valid && mdu_ready && (bus.mdu_dir != '0);
    assign pop       = !alu_eff && (cnt != 2'd0);

    // Squash runs before the push so an MDU result arriving alongside an ALU
    // write to the same register stays valid as the newer value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                qdir[i]  <= '0;
                qdata[i] <= '0;
            end
            qvld <= 2'b00;
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (alu_eff) begin
                for (int i = 0; i < 2; i++) begin
                    if (qdir[i] == bus.alu_dir) begin
                        qvld[i] <= 1'b0;
                    end
                end
            end
            if (push) begin
                qdir[wptr]  <= bus.mdu_dir;
                qdata[wptr] <= bus.mdu_data;
                qvld[wptr]  <= 1'b1;
                wptr        <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_dir  <= '0;
            wr_data <= '0;
        end else if (alu_eff) begin
            wr_en   <= 1'b1;
            wr_dir  <= bus.alu_dir;
            wr_data <= bus.alu_data;
        end else if (pop && qvld[rptr]) begin
            wr_en   <= 1'b1;
            wr_dir  <= qdir[rptr];
            wr_data <= qdata[rptr];
        end else begin
            wr_en <= 1'b0;
        end
    end

    assign bus.mdu_ready = mdu_ready;
    assign bus.RegWrite  = wr_en;
    assign bus.writer    = wr_dir;
    assign bus.writedata = wr_data;
    assign bus.pend_cnt  = cnt;

endmodule

// File: tb/tb_reg_write_port.sv
// Directed bench for reg_write_port: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_reg_write_port;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_write_port_if #(.REG_WIDTH(8), .REG_DIR_WIDTH(3)) bus ();

    reg_write_port #(.REG_WIDTH(8), .REG_DIR_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [2:0] ad, input logic [7:0] adata,
                                 input logic mv, input logic [2:0] md, input logic [7:0] mdata);
        bus.alu_valid = av;
        bus.alu_dir   = ad;
        bus.alu_data  = adata;
        bus.mdu_valid = mv;
        bus.mdu_dir   = md;
        bus.mdu_data  = mdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWrite(input string tag, input logic we, input logic [2:0] dir, input logic [7:0] data);
        checkOutput({tag, ".RegWrite"}, {31'd0, bus.RegWrite}, {31'd0, we});
        checkOutput({tag, ".writer"}, {29'd0, bus.writer}, {29'd0, dir});
        checkOutput({tag, ".writedata"}, {24'd0, bus.writedata}, {24'd0, data});
    endtask

    task automatic checkQueue(input string tag, input logic [1:0] cnt, input logic rdy);
        checkOutput({tag, ".pend_cnt"}, {30'd0, bus.pend_cnt}, {30'd0, cnt});
        checkOutput({tag, ".mdu_ready"}, {31'd0, bus.mdu_ready}, {31'd0, rdy});
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset with random inputs
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom), 3'($urandom), 8'($urandom),
                          1'($urandom), 3'($urandom), 8'($urandom));
            tick();
        end
        checkWrite("reset", 1'b0, 3'd0, 8'h00);
        checkQueue("reset", 2'd0, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        checkWrite("post_reset", 1'b0, 3'd0, 8'h00);

        // ALU only
        applyStimulus(1, 3'd5, 8'h3C, 0, 0, 0);
        tick();
        checkWrite("alu5", 1'b1, 3'd5, 8'h3C);
        applyStimulus(1, 3'd0, 8'h77, 0, 0, 0);
        tick();
        checkWrite("alu_dir0", 1'b0, 3'd5, 8'h3C);

        // Back-pressure: six ALU writes while MDU offers three results
        for (int i = 1; i <= 6; i++) begin
            if (i == 1)      applyStimulus(1, 3'd1, 8'(i), 1, 3'd2, 8'h11);
            else if (i == 2) applyStimulus(1, 3'd1, 8'(i), 1, 3'd3, 8'h22);
            else             applyStimulus(1, 3'd1, 8'(i), 1, 3'd4, 8'h33);
            tick();
            checkWrite($sformatf("bp_alu%0d", i), 1'b1, 3'd1, 8'(i));
            if (i == 1) checkQueue("bp_c1", 2'd1, 1'b1);
            if (i >= 2) checkQueue($sformatf("bp_full%0d", i), 2'd2, 1'b0);
        end
        applyStimulus(0, 0, 0, 1, 3'd4, 8'h33);
        tick();
        checkWrite("bp_pop2", 1'b1, 3'd2, 8'h11);
        checkQueue("bp_pop2", 2'd1, 1'b1);
        tick();
        checkWrite("bp_pop3", 1'b1, 3'd3, 8'h22);
        checkQueue("bp_pop3", 2'd1, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkWrite("bp_pop4", 1'b1, 3'd4, 8'h33);
        checkQueue("bp_pop4", 2'd0, 1'b1);
        tick();
        checkWrite("bp_idle", 1'b0, 3'd4, 8'h33);

        // Squash: queued 6/AA overridden by ALU 6/55
        applyStimulus(0, 0, 0, 1, 3'd6, 8'hAA);
        tick();
        checkWrite("sq_push", 1'b0, 3'd4, 8'h33);
        checkQueue("sq_push", 2'd1, 1'b1);
        applyStimulus(1, 3'd6, 8'h55, 0, 0, 0);
        tick();
        checkWrite("sq_alu", 1'b1, 3'd6, 8'h55);
        checkQueue("sq_alu", 2'd1, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkWrite("sq_pop", 1'b0, 3'd6, 8'h55);
        checkQueue("sq_pop", 2'd0, 1'b1);
        tick();
        checkWrite("sq_idle", 1'b0, 3'd6, 8'h55);

        // Simultaneous push and pop, then a dir-0 discard
        applyStimulus(0, 0, 0, 1, 3'd2, 8'h44);
        tick();
        checkQueue("sim_push", 2'd1, 1'b1);
        applyStimulus(0, 0, 0, 1, 3'd3, 8'h66);
        tick();
        checkWrite("sim_pushpop", 1'b1, 3'd2, 8'h44);
        checkQueue("sim_pushpop", 2'd1, 1'b1);
        applyStimulus(1, 3'd7, 8'h12, 1, 3'd0, 8'h99);
        tick();
        checkWrite("sim_dir0", 1'b1, 3'd7, 8'h12);
        checkQueue("sim_dir0", 2'd1, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkWrite("sim_drain", 1'b1, 3'd3, 8'h66);
        checkQueue("sim_drain", 2'd0, 1'b1);

        // ALU and MDU to the same register in one cycle: MDU is newer
        applyStimulus(1, 3'd5, 8'h10, 1, 3'd5, 8'h20);
        tick();
        checkWrite("same_alu", 1'b1, 3'd5, 8'h10);
        checkQueue("same_alu", 2'd1, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkWrite("same_mdu", 1'b1, 3'd5, 8'h20);

        // Reset mid-stream with two entries queued
        applyStimulus(1, 3'd7, 8'h01, 1, 3'd2, 8'hC1);
        tick();
        applyStimulus(1, 3'd7, 8'h02, 1, 3'd3, 8'hC2);
        tick();
        checkQueue("mid_full", 2'd2, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        checkQueue("mid_rst", 2'd0, 1'b1);
        checkWrite("mid_rst", 1'b0, 3'd0, 8'h00);
        #2;
        rst = 1'b1;
        tick();
        checkWrite("mid_rel1", 1'b0, 3'd0, 8'h00);
        checkQueue("mid_rel1", 2'd0, 1'b1);
        tick();
        checkWrite("mid_rel2", 1'b0, 3'd0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
